// File: rtl/bf_pkg.sv
// Shared types and constants for the beamformer weight loader.
// Holds the SPI command word layout, opcode/bank enums and the loader FSM states.
package bf_pkg;

    localparam int BF_N_ELEM = 8;
    localparam int BF_W_W    = 5;
    localparam int BF_WORD_W = 16;

    typedef enum logic [1:0] {
        OP_NOP,
        OP_WRITE,
        OP_COMMIT,
        OP_CLEAR
    } bf_wl_op_e;

    typedef enum logic [1:0] {
        SET_COS1,
        SET_SIN1,
        SET_COS2,
        SET_SIN2
    } bf_wl_set_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_EXEC
    } bf_wl_state_e;

    typedef struct packed {
        bf_wl_op_e  op;
        bf_wl_set_e bank;
        logic [2:0] elem;
        logic [3:0] rsvd;
        logic [4:0] weight;
    } bf_wl_word_t;

    // Bit offset of an element's weight inside a flattened bank.
    function automatic int bf_lsb(input logic [2:0] elem, input int w_w);
        return int'(elem) * w_w;
    endfunction

endpackage

// File: rtl/bf_spi_if.sv
// SPI bus bundle between the host (master) and the weight loader (slave).
interface bf_spi_if;

    logic sclk;
    logic ss_n;
    logic mosi;
    logic miso;

    modport master (output sclk, output ss_n, output mosi, input miso);
    modport slave  (input sclk, input ss_n, input mosi, output miso);

endinterface

// File: rtl/bf_spi_sync.sv
// Brings the asynchronous SPI pins into the system clock domain and
// produces registered one-cycle SCLK edge pulses aligned with the sampled MOSI.
module bf_spi_sync (
    input  logic clock,
    input  logic reset_n,
    input  logic sclk,
    input  logic ss_n,
    input  logic mosi,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic ss_n_s,
    output logic mosi_s
);

    logic [1:0] sclk_ff;
    logic [1:0] ss_ff;
    logic [1:0] mosi_ff;
    logic       sclk_d;

    // Idle levels on reset keep a deselected bus from looking like an edge.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            sclk_ff   <= 2'b00;
            ss_ff     <= 2'b11;
            mosi_ff   <= 2'b00;
            sclk_d    <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            mosi_s    <= 1'b0;
        end else begin
            sclk_ff   <= {sclk_ff[0], sclk};
            ss_ff     <= {ss_ff[0], ss_n};
            mosi_ff   <= {mosi_ff[0], mosi};
            sclk_d    <= sclk_ff[1];
            sclk_rise <= sclk_ff[1] & ~sclk_d;
            sclk_fall <= ~sclk_ff[1] & sclk_d;
            mosi_s    <= mosi_ff[1];
        end
    end

    assign ss_n_s = ss_ff[1];

endmodule

// File: rtl/bf_weight_loader.sv
// SPI slave loading beamformer phase weights into a shadow bank, with an atomic COMMIT to outputs.
// Optional readback of the previous word on MISO when BF_WLOAD_MISO_EN is defined.
module bf_weight_loader
    import bf_pkg::*;
#(
    parameter int N_ELEM = BF_N_ELEM,
    parameter int W_W    = BF_W_W,
    parameter int WORD_W = BF_WORD_W
) (
    input  logic                    clock,
    input  logic                    reset_n,
    bf_spi_if.slave                 spi,
    output logic [N_ELEM*W_W-1:0]   w_cos_1,
    output logic [N_ELEM*W_W-1:0]   w_sin_1,
    output logic [N_ELEM*W_W-1:0]   w_cos_2,
    output logic [N_ELEM*W_W-1:0]   w_sin_2,
    output logic                    weights_valid,
    output logic                    frame_err
);

    localparam int CNT_W = $clog2(WORD_W + 1);

    logic sclk_rise;
    logic sclk_fall;
    logic ss_n_s;
    logic mosi_s;

    bf_wl_state_e                    state;
    logic [CNT_W-1:0]                bit_cnt;
    logic [WORD_W-1:0]               shreg;
    logic [3:0][N_ELEM*W_W-1:0]      shadow;
    logic [3:0][N_ELEM*W_W-1:0]      active;
    bf_wl_word_t                     cmd;

    bf_spi_sync u_sync (
        .clock     (clock),
        .reset_n   (reset_n),
        .sclk      (spi.sclk),
        .ss_n      (spi.ss_n),
        .mosi      (spi.mosi),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .ss_n_s    (ss_n_s),
        .mosi_s    (mosi_s)
    );

    assign cmd = bf_wl_word_t'(shreg);

    // EXEC lasts exactly one cycle; a COMMIT copies the entire shadow so outputs switch atomically.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            bit_cnt       <= '0;
            shreg         <= '0;
            shadow        <= '0;
            active        <= '0;
            weights_valid <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            weights_valid <= 1'b0;
            frame_err     <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    bit_cnt <= '0;
                    if (!ss_n_s) begin
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (ss_n_s) begin
                        if (bit_cnt != '0) begin
                            frame_err <= 1'b1;
                        end
                        bit_cnt <= '0;
                        state   <= ST_IDLE;
                    end else if (sclk_rise) begin
                        shreg   <= {shreg[WORD_W-2:0], mosi_s};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == CNT_W'(WORD_W - 1)) begin
                            state <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    bit_cnt <= '0;
                    unique case (cmd.op)
                        OP_WRITE:  shadow[cmd.bank][bf_lsb(cmd.elem, W_W) +: W_W] <= W_W'(cmd.weight);
                        OP_COMMIT: begin
                            active        <= shadow;
                            weights_valid <= 1'b1;
                        end
                        OP_CLEAR:  shadow <= '0;
                        OP_NOP:    ;
                    endcase
                    state <= ss_n_s ? ST_IDLE : ST_SHIFT;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign w_cos_1 = active[SET_COS1];
    assign w_sin_1 = active[SET_SIN1];
    assign w_cos_2 = active[SET_COS2];
    assign w_sin_2 = active[SET_SIN2];

    logic unused_rsvd;
    assign unused_rsvd = ^cmd.rsvd;

`ifdef BF_WLOAD_MISO_EN
    logic [WORD_W-1:0] tx_reg;
    logic              miso_q;

    // Falls before the first rise of a word (bit_cnt == 0) are ignored so the MSB is held for bit 0.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            tx_reg <= '0;
            miso_q <= 1'b0;
        end else if (ss_n_s) begin
            miso_q <= 1'b0;
        end else if (state == ST_EXEC) begin
            tx_reg <= shreg;
            miso_q <= shreg[WORD_W-1];
        end else if (state == ST_IDLE) begin
            miso_q <= tx_reg[WORD_W-1];
        end else if (sclk_fall && bit_cnt != '0) begin
            tx_reg <= {tx_reg[WORD_W-2:0], 1'b0};
            miso_q <= tx_reg[WORD_W-2];
        end
    end

    assign spi.miso = miso_q;
`else
    logic unused_fall;
    assign unused_fall = sclk_fall;
    assign spi.miso    = 1'b0;
`endif

endmodule

// File: tb/tb_bf_weight_loader.sv
// Scoreboard bench for bf_weight_loader: a word-level model queues expected banks on each COMMIT.
module tb_bf_weight_loader;
    import bf_pkg::*;

    localparam int HALF = 8;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    bf_spi_if spi ();

    logic [39:0] w_cos_1, w_sin_1, w_cos_2, w_sin_2;
    logic        weights_valid, frame_err;

    bf_weight_loader dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .spi           (spi),
        .w_cos_1       (w_cos_1),
        .w_sin_1       (w_sin_1),
        .w_cos_2       (w_cos_2),
        .w_sin_2       (w_sin_2),
        .weights_valid (weights_valid),
        .frame_err     (frame_err)
    );

    int check_cnt = 0;
    int pass_cnt = 0;
    int cycle_cnt = 0;
    int last_rise_cycle = 0;
    int fe_seen = 0;
    int fe_exp = 0;

    logic [3:0][39:0] m_shadow = '0;
    logic [3:0][39:0] m_active = '0;
    logic [159:0]     exp_q[$];
    logic [159:0]     exp_banks;
    logic [15:0]      miso_cap = '0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        check_cnt++;
        if (got === want) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic model_exec(input logic [15:0] word);
        case (word[15:14])
            2'b01: m_shadow[word[13:12]][int'(word[11:9]) * 5 +: 5] = word[4:0];
            2'b10: begin
                m_active = m_shadow;
                exp_q.push_back(m_shadow);
            end
            2'b11: m_shadow = '0;
            default: ;
        endcase
    endtask

    // Mode-0 host: MOSI changes with SCLK low, MISO captured at each rise.
    task automatic applyStimulus(input logic [15:0] word, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            spi.mosi = word[15-i];
            repeat (HALF) @(posedge clock);
            #1;
            spi.sclk = 1'b1;
            last_rise_cycle = cycle_cnt;
            miso_cap = {miso_cap[14:0], spi.miso};
            if (i == 15) model_exec(word);
            repeat (HALF) @(posedge clock);
            #1;
            spi.sclk = 1'b0;
        end
    endtask

    task automatic end_frame();
        repeat (HALF) @(posedge clock);
        #1;
        spi.ss_n = 1'b1;
        repeat (2 * HALF) @(posedge clock);
        #1;
    endtask

    task automatic check_banks(input string tag);
        checkOutput({tag, "_cos1"}, 64'(w_cos_1), 64'(m_active[0]));
        checkOutput({tag, "_sin1"}, 64'(w_sin_1), 64'(m_active[1]));
        checkOutput({tag, "_cos2"}, 64'(w_cos_2), 64'(m_active[2]));
        checkOutput({tag, "_sin2"}, 64'(w_sin_2), 64'(m_active[3]));
    endtask

    always @(posedge clock) begin
        cycle_cnt++;
        #1;
        if (frame_err) fe_seen++;
        if (weights_valid) begin
            checkOutput("valid_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                exp_banks = exp_q.pop_front();
                checkOutput("commit_cos1", 64'(w_cos_1), 64'(exp_banks[39:0]));
                checkOutput("commit_sin1", 64'(w_sin_1), 64'(exp_banks[79:40]));
                checkOutput("commit_cos2", 64'(w_cos_2), 64'(exp_banks[119:80]));
                checkOutput("commit_sin2", 64'(w_sin_2), 64'(exp_banks[159:120]));
                checkOutput("commit_latency", 64'(cycle_cnt - last_rise_cycle), 64'd5);
            end
        end
    end

    initial begin
        spi.sclk = 1'b0;
        spi.ss_n = 1'b1;
        spi.mosi = 1'b0;
        reset_n  = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        check_banks("reset");
        checkOutput("reset_valid", 64'(weights_valid), 64'd0);
        checkOutput("reset_frame_err", 64'(frame_err), 64'd0);
        checkOutput("reset_miso", 64'(spi.miso), 64'd0);
        reset_n = 1'b1;
        repeat (4) @(posedge clock);
        #1;

        $display("[TB] write then commit");
        spi.ss_n = 1'b0;
        applyStimulus(16'h4A0B, 16);
        end_frame();
        check_banks("after_write");
        spi.ss_n = 1'b0;
        applyStimulus(16'h8000, 16);
        end_frame();
        checkOutput("elem5_weight", 64'(w_cos_1[29:25]), 64'd11);

        $display("[TB] aborted word");
        spi.ss_n = 1'b0;
        applyStimulus(16'h4FFF, 9);
        fe_exp++;
        end_frame();
        checkOutput("abort_frame_err", 64'(fe_seen), 64'(fe_exp));
        spi.ss_n = 1'b0;
        applyStimulus(16'h7415, 16);
        applyStimulus(16'h8000, 16);
        end_frame();

        $display("[TB] write/clear/commit burst");
        spi.ss_n = 1'b0;
        applyStimulus(16'h5E1F, 16);
        applyStimulus(16'hC000, 16);
        applyStimulus(16'h8000, 16);
        end_frame();
        checkOutput("burst_sin1_e7", 64'(w_sin_1[39:35]), 64'd0);
        check_banks("after_clear");

        $display("[TB] reset inside a commit word");
        spi.ss_n = 1'b0;
        applyStimulus(16'h4007, 16);
        applyStimulus(16'h8000, 16);
        applyStimulus(16'h8000, 12);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        m_shadow = '0;
        m_active = '0;
        repeat (2) @(posedge clock);
        #1;
        check_banks("mid_reset");
        applyStimulus(16'h6C1A, 16);
        applyStimulus(16'h8000, 16);
        end_frame();
        checkOutput("post_reset_cos2_e6", 64'(w_cos_2[34:30]), 64'd26);

        $display("[TB] miso readback");
        spi.ss_n = 1'b0;
        applyStimulus(16'h4A0B, 16);
        applyStimulus(16'h0000, 16);
        end_frame();
`ifdef BF_WLOAD_MISO_EN
        checkOutput("miso_word", 64'(miso_cap), 64'h4A0B);
`else
        checkOutput("miso_word", 64'(miso_cap), 64'h0000);
`endif
        checkOutput("miso_idle", 64'(spi.miso), 64'd0);

        repeat (4) @(posedge clock);
        #1;
        checkOutput("frame_err_total", 64'(fe_seen), 64'(fe_exp));
        checkOutput("pending_commits", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
